control_multiplicador_fp: RTL and testbench
===========================================

// Module: control_multiplicador_fp
// PURPOSE
//  Sequences a shared 8x8 mantissa multiplier (hidden-1 format, mantissa + exponent-carry flag)
//  to perform full floating-point products for two requesters (A, B).
//  Round-robin arbitrates, drives multiplier operands, computes sign/exponent,
//  flags overflow/underflow, and returns the result through a valid/ready handshake.
//  Word format: {sign[1], exponent[EXP_W], mantissa[8]}, bias = 2^(EXP_W-1)-1.
// PARAMETERS
//  EXP_W       7  exponent width; word width W = EXP_W+9 (16 by default)
//  MUL_ESPERA  1  cycles multiplier operands are held before its result is sampled (>=1)
// PORTS
//  i_clk              in   1   clock, rising edge
//  i_rst_n            in   1   reset, asynchronous, active-low
//  i_valid_a/b        in   1   requester A/B has an operand pair
//  i_op1_a/b,i_op2_a/b in  W   operand words of requester A/B
//  o_ready_a/b        out  1   request accepted this cycle when valid&ready
//  o_mul_mantiza_1/2  out  8   operands to shared mantissa multiplier (registered)
//  i_mul_mantiza      in   8   multiplier mantissa result
//  i_mul_aviso        in   1   multiplier exponent-increment flag
//  o_valid            out  1   result available
//  i_ready            in   1   consumer accepts result
//  o_resultado        out  W   product word
//  o_id               out  1   0 = result belongs to A, 1 = B
//  o_overflow         out  1   result saturated to max exponent
//  o_underflow        out  1   result flushed to zero
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; all outputs 0; counter 0; last-served = B (A wins first).
//  FSM: IDLE -> MULT -> EXP -> SALIDA -> IDLE.
//  IDLE: grant = only valid requester; if both valid, the one not served last.
//   o_ready_x = (state==IDLE) & grant_x, combinational; never both high.
//   On handshake: latch operands, sign, exponents, id; load multiplier operand regs; go MULT.
//  MULT: operand regs stable; counter counts MUL_ESPERA cycles; on last cycle sample
//   i_mul_mantiza/i_mul_aviso into regs; go EXP.
//  EXP: e = e1 + e2 - bias + aviso, signed EXP_W+2 bits; sign = s1^s2.
//   e >= 2^EXP_W-1 -> exponent all ones, mantissa 0, overflow=1.
//   e <= 0         -> whole word 0 (sign cleared), underflow=1.
//   else exponent e[EXP_W-1:0], mantissa = sampled multiplier mantissa. Go SALIDA.
//  SALIDA: o_valid=1, o_resultado/o_id/flags stable until i_ready; on o_valid&i_ready
//   deassert o_valid next cycle, update last-served, go IDLE.
//  Latency handshake -> o_valid: MUL_ESPERA+2 cycles (3 default). Throughput: 1 op per
//   MUL_ESPERA+3 cycles min. Flags valid only with o_valid; cleared on return to IDLE.
//  No new request accepted outside IDLE; requester valids must hold until ready.
//  Reset mid-operation discards the op; no partial result is ever presented.
// CONFIGURATION
//  FP_CERO_DETECT_EN defined: operand with exponent==0 counts as zero; result word 0
//   (sign cleared), flags 0, same latency and FSM path (multiplier still sequenced).
//  Not defined: exponent-0 operands processed arithmetically (normally underflow).
// TESTING (EXP_W=7, MUL_ESPERA=1, bench multiplier stub returns given values)
//  A: 0x3F80 x 0x3F80, stub 0x20/aviso 1 -> o_resultado 0x4020, o_id 0, valid 3 cycles after accept.
//  A: 0xBF80 x 0x3F80, stub 0x20/1 -> 0xC020; with i_ready low 5 cycles output held stable.
//  0x7E00 x 0x7E00 -> 0x7F00, o_overflow 1; 0x0100 x 0x0100 -> 0x0000, o_underflow 1.
//  A and B valid together after reset -> A served first, then B; A re-requests -> B first.
//  i_rst_n low during MULT -> all outputs 0 at once; no o_valid for aborted op.
//  FP_CERO_DETECT_EN: 0x0080 x 0x3F80 -> 0x0000, flags 0; without macro -> o_underflow 1.

Source files
------------

// File: rtl/control_multiplicador_fp.sv
// Sequencer for a shared 8x8 mantissa multiplier. It produces floating-point products for two
// round-robin requesters. Optional build macro: FP_CERO_DETECT_EN (an exponent-0 operand is treated as zero).
//
// state    | meaning
// S_IDLE   | waiting for a request; grants one requester by round-robin
// S_MULT   | multiplier operands held for MUL_ESPERA cycles, result sampled on the last one
// S_EXP    | sign/exponent computed, overflow/underflow resolved, result registered
// S_SALIDA | result presented on o_valid until the consumer takes it
module control_multiplicador_fp #(
   parameter int EXP_W      = 7,
   parameter int MUL_ESPERA = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid_a,
   input  logic               i_valid_b,
   input  logic [EXP_W+8:0]   i_op1_a,
   input  logic [EXP_W+8:0]   i_op2_a,
   input  logic [EXP_W+8:0]   i_op1_b,
   input  logic [EXP_W+8:0]   i_op2_b,
   output logic               o_ready_a,
   output logic               o_ready_b,
   output logic [7:0]         o_mul_mantiza_1,
   output logic [7:0]         o_mul_mantiza_2,
   input  logic [7:0]         i_mul_mantiza,
   input  logic               i_mul_aviso,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [EXP_W+8:0]   o_resultado,
   output logic               o_id,
   output logic               o_overflow,
   output logic               o_underflow
);

   localparam int W     = EXP_W + 9;
   localparam int CNT_W = (MUL_ESPERA > 1) ? $clog2(MUL_ESPERA) : 1;
   localparam logic [CNT_W-1:0] CNT_INI     = CNT_W'(MUL_ESPERA - 1);
   localparam logic [EXP_W+1:0] BIAS_EXT    = (EXP_W+2)'(2**(EXP_W-1) - 1);
   localparam logic [EXP_W+1:0] EXP_MAX_EXT = (EXP_W+2)'(2**EXP_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_EXP, S_SALIDA} state_t;

   state_t             state, state_nxt;
   logic               grant_a, grant_b;
   logic               ultimo_b;
   logic [CNT_W-1:0]   cnt;
   logic [W-1:0]       op1_sel, op2_sel;
   logic               cero_op;
   logic [EXP_W-1:0]   e1_q, e2_q;
   logic               signo_q, id_q, cero_q, aviso_q;
   logic [7:0]         mant_q;
   logic [EXP_W+1:0]   e_sum;
   logic               ovf, unf;
   logic [W-1:0]       res_calc;

   always_comb begin
      grant_a   = i_valid_a & (~i_valid_b | ultimo_b);
      grant_b   = i_valid_b & (~i_valid_a | ~ultimo_b);
      o_ready_a = (state == S_IDLE) & grant_a;
      o_ready_b = (state == S_IDLE) & grant_b;
      op1_sel   = grant_b ? i_op1_b : i_op1_a;
      op2_sel   = grant_b ? i_op2_b : i_op2_a;
      state_nxt = state;
      case (state)
         S_IDLE:   if (grant_a | grant_b) state_nxt = S_MULT;
         S_MULT:   if (cnt == '0)         state_nxt = S_EXP;
         S_EXP:                           state_nxt = S_SALIDA;
         S_SALIDA: if (i_ready)           state_nxt = S_IDLE;
         default:                         state_nxt = S_IDLE;
      endcase
   end

`ifdef FP_CERO_DETECT_EN
   assign cero_op = (op1_sel[W-2 -: EXP_W] == '0) | (op2_sel[W-2 -: EXP_W] == '0);
`else
   assign cero_op = 1'b0;
`endif

   // Unsigned sum read as a signed EXP_W+2 value; its range never reaches the sign bit from above.
   always_comb begin
      e_sum    = {2'b00, e1_q} + {2'b00, e2_q} + {{(EXP_W+1){1'b0}}, aviso_q} - BIAS_EXT;
      ovf      = ~e_sum[EXP_W+1] & (e_sum >= EXP_MAX_EXT);
      unf      = e_sum[EXP_W+1] | (e_sum == '0);
      res_calc = '0;
      if (cero_q)
         res_calc = '0;
      else if (ovf)
         res_calc = {signo_q, {EXP_W{1'b1}}, 8'h00};
      else if (unf)
         res_calc = '0;
      else
         res_calc = {signo_q, e_sum[EXP_W-1:0], mant_q};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ultimo_b        <= 1'b1;
         cnt             <= '0;
         e1_q            <= '0;
         e2_q            <= '0;
         signo_q         <= 1'b0;
         id_q            <= 1'b0;
         cero_q          <= 1'b0;
         aviso_q         <= 1'b0;
         mant_q          <= '0;
         o_mul_mantiza_1 <= '0;
         o_mul_mantiza_2 <= '0;
         o_valid         <= 1'b0;
         o_resultado     <= '0;
         o_id            <= 1'b0;
         o_overflow      <= 1'b0;
         o_underflow     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_a | grant_b) begin
                  e1_q            <= op1_sel[W-2 -: EXP_W];
                  e2_q            <= op2_sel[W-2 -: EXP_W];
                  signo_q         <= op1_sel[W-1] ^ op2_sel[W-1];
                  id_q            <= grant_b;
                  cero_q          <= cero_op;
                  o_mul_mantiza_1 <= op1_sel[7:0];
                  o_mul_mantiza_2 <= op2_sel[7:0];
                  cnt             <= CNT_INI;
               end
            end
            S_MULT: begin
               if (cnt == '0) begin
                  mant_q  <= i_mul_mantiza;
                  aviso_q <= i_mul_aviso;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_EXP: begin
               o_resultado <= res_calc;
               o_overflow  <= ~cero_q & ovf;
               o_underflow <= ~cero_q & ~ovf & unf;
               o_id        <= id_q;
               o_valid     <= 1'b1;
            end
            S_SALIDA: begin
               if (i_ready) begin
                  o_valid     <= 1'b0;
                  o_overflow  <= 1'b0;
                  o_underflow <= 1'b0;
                  ultimo_b    <= o_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_multiplicador_fp.sv
// Randomized bench for control_multiplicador_fp; expected products come from an integer-arithmetic model.
// Build with +define+FP_CERO_DETECT_EN to check the zero-detect variant.
module tb_control_multiplicador_fp;

   localparam int EXP_W = 7;
   localparam int W     = EXP_W + 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_valid_a, i_valid_b;
   logic [W-1:0]  op1_a, op2_a, op1_b, op2_b;
   logic          o_ready_a, o_ready_b;
   logic [7:0]    o_mul_mantiza_1, o_mul_mantiza_2;
   logic [7:0]    i_mul_mantiza;
   logic          i_mul_aviso;
   logic          o_valid, i_ready;
   logic [W-1:0]  o_resultado;
   logic          o_id, o_overflow, o_underflow;

   int   n_cmp = 0;
   int   n_err = 0;
   logic last_b;

   always #5 clk = ~clk;

   control_multiplicador_fp #(.EXP_W(EXP_W), .MUL_ESPERA(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_valid_a(i_valid_a), .i_valid_b(i_valid_b),
      .i_op1_a(op1_a), .i_op2_a(op2_a), .i_op1_b(op1_b), .i_op2_b(op2_b),
      .o_ready_a(o_ready_a), .o_ready_b(o_ready_b),
      .o_mul_mantiza_1(o_mul_mantiza_1), .o_mul_mantiza_2(o_mul_mantiza_2),
      .i_mul_mantiza(i_mul_mantiza), .i_mul_aviso(i_mul_aviso),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_resultado(o_resultado), .o_id(o_id),
      .o_overflow(o_overflow), .o_underflow(o_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Floating-point product from the word-format rules, using plain integers.
   function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [7:0] m, input logic av,
                                              output logic ov, output logic un);
      int   ea, eb, e;
      logic s;
      ea = int'(a[W-2 -: EXP_W]);
      eb = int'(b[W-2 -: EXP_W]);
      s  = a[W-1] ^ b[W-1];
      e  = ea + eb - (2**(EXP_W-1) - 1) + int'(av);
      ov = 1'b0;
      un = 1'b0;
`ifdef FP_CERO_DETECT_EN
      if (ea == 0 || eb == 0) return '0;
`endif
      if (e >= 2**EXP_W - 1) begin
         ov = 1'b1;
         return {s, {EXP_W{1'b1}}, 8'h00};
      end
      if (e <= 0) begin
         un = 1'b1;
         return '0;
      end
      return {s, e[EXP_W-1:0], m};
   endfunction

   // Called at a negedge with the pending valids already driven; runs one full transaction.
   task automatic serve(input logic [7:0] m, input logic av, input int stall);
      int          n;
      logic        gb, eov, eun;
      logic [W-1:0] x, y, er, held;
      gb = (i_valid_a && i_valid_b) ? ~last_b : i_valid_b;
      x  = gb ? op1_b : op1_a;
      y  = gb ? op2_b : op2_a;
      i_mul_mantiza = m;
      i_mul_aviso   = av;
      #1;
      check("ready_grant", {30'd0, o_ready_a, o_ready_b}, gb ? 32'd1 : 32'd2);
      @(posedge clk);
      @(negedge clk);
      if (gb) i_valid_b = 1'b0; else i_valid_a = 1'b0;
      n = 1;
      check("mul_op1", o_mul_mantiza_1, x[7:0]);
      check("mul_op2", o_mul_mantiza_2, y[7:0]);
      check("busy_no_ready", {31'd0, o_ready_a | o_ready_b}, 0);
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 2) i_mul_mantiza = ~m;
      end
      check("latency", n, 3);
      er = ref_model(x, y, m, av, eov, eun);
      check("resultado", o_resultado, er);
      check("id", {31'd0, o_id}, {31'd0, gb});
      check("overflow", {31'd0, o_overflow}, {31'd0, eov});
      check("underflow", {31'd0, o_underflow}, {31'd0, eun});
      held = o_resultado;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, o_valid}, 1);
         check("hold_res", o_resultado, held);
      end
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check("valid_drop", {31'd0, o_valid}, 0);
      check("flags_clr", {30'd0, o_overflow, o_underflow}, 0);
      last_b = gb;
   endtask

   task automatic req_a(input logic [W-1:0] a1, input logic [W-1:0] a2);
      op1_a = a1; op2_a = a2; i_valid_a = 1'b1;
   endtask

   task automatic req_b(input logic [W-1:0] b1, input logic [W-1:0] b2);
      op1_b = b1; op2_b = b2; i_valid_b = 1'b1;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      v = W'($urandom);
      v[7] = 1'b1;
      return v;
   endfunction

   initial begin
      bit seen_valid;
      rst_n = 1'b0; i_valid_a = 1'b0; i_valid_b = 1'b0; i_ready = 1'b0;
      op1_a = '0; op2_a = '0; op1_b = '0; op2_b = '0;
      i_mul_mantiza = '0; i_mul_aviso = 1'b0;
      last_b = 1'b1;
      #1;
      check("rst_valid", {31'd0, o_valid}, 0);
      check("rst_outs", {o_resultado, o_mul_mantiza_1, o_mul_mantiza_2},
            {W'(0), 8'd0, 8'd0});
      check("rst_flags", {28'd0, o_id, o_overflow, o_underflow, o_ready_a}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      req_a(16'h3F80, 16'h3F80); serve(8'h20, 1'b1, 0);
      req_a(16'hBF80, 16'h3F80); serve(8'h20, 1'b1, 5);
      req_a(16'h7E00, 16'h7E00); serve(8'h55, 1'b0, 1);
      req_b(16'h0100, 16'h0100); serve(8'h80, 1'b0, 0);
      req_a(16'h0080, 16'h3F80); serve(8'h40, 1'b0, 2);

      // Abort an operation during the multiply phase.
      req_a(16'h4080, 16'h3F80);
      #1;
      @(posedge clk);
      @(negedge clk);
      i_valid_a = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_valid", {31'd0, o_valid}, 0);
      check("abort_outs", {o_resultado, o_mul_mantiza_1, o_mul_mantiza_2},
            {W'(0), 8'd0, 8'd0});
      last_b = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (o_valid) seen_valid = 1'b1;
      end
      check("abort_no_valid", {31'd0, seen_valid}, 0);

      // Simultaneous requests after reset, then A re-requests while B waits.
      req_a(16'h3F90, 16'h4081);
      req_b(16'hC0A0, 16'h3F85);
      serve(8'h91, 1'b0, 0);
      req_a(16'h3E88, 16'h4188);
      serve(8'hA5, 1'b1, 0);
      serve(8'hC3, 1'b0, 1);

      for (int it = 0; it < 60; it++) begin
         if (!i_valid_a && $urandom_range(0, 1) == 1) req_a(rand_word(), rand_word());
         if (!i_valid_b && $urandom_range(0, 1) == 1) req_b(rand_word(), rand_word());
         if (!i_valid_a && !i_valid_b) req_a(rand_word(), rand_word());
         serve(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
